// File: rtl/pe_stream_feeder_pkg.sv
// Shared definitions for the PE column feeder: FSM state encoding and the
// width helpers that the PE array uses for its select and count ports.
package pe_stream_feeder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_W = 3'd1;
  localparam state_t ST_ARM    = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // A single-entry filter still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int num_col_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pe_stream_feeder_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module pe_feed_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pe_stream_feeder.sv
// Drives one PE column: loads the sparse nonzero weights, arms the PE, then
// streams features and holds start_op through the drain of the filter window.
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
#(
  parameter int I_WIDTH       = 8,
  parameter int F_WIDTH       = 8,
  parameter int N             = 3,
  parameter int SEL_WIDTH     = sel_width(N),
  parameter int NUM_COL_WIDTH = num_col_width(N),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_valid_i,
  input  logic [NUM_COL_WIDTH-1:0] cfg_filter_size_i,
  input  logic [NUM_COL_WIDTH-1:0] cfg_row_num_i,
  input  logic [CNT_WIDTH-1:0]     cfg_num_feat_i,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  input  logic [F_WIDTH-1:0]       w_data_i,
  input  logic [SEL_WIDTH-1:0]     w_col_i,
  input  logic                     w_last_i,
  input  logic                     feat_valid_i,
  output logic                     feat_ready_o,
  input  logic [I_WIDTH-1:0]       feat_data_i,
  output logic                     pe_load_o,
  output logic                     pe_ready_o,
  output logic                     pe_start_op_o,
  output logic [F_WIDTH-1:0]       pe_f_weight_o,
  output logic [SEL_WIDTH-1:0]     pe_f_sel_o,
  output logic [NUM_COL_WIDTH-1:0] pe_column_num_o,
  output logic [NUM_COL_WIDTH-1:0] pe_row_num_o,
  output logic [NUM_COL_WIDTH-1:0] pe_filter_size_o,
  output logic [I_WIDTH-1:0]       pe_in_feature_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam logic [NUM_COL_WIDTH-1:0] N_MAX = NUM_COL_WIDTH'(N);

  state_t                   state;
  logic [NUM_COL_WIDTH-1:0] entry_cnt;

  logic                     w_fire;
  logic                     w_keep;
  logic                     feat_fire;
  logic [CNT_WIDTH-1:0]     feat_count;
  logic                     feat_zero;
  logic [NUM_COL_WIDTH-1:0] drain_count;
  logic                     drain_zero;

  // Both ready outputs are flops, so they never depend on valid in the same cycle.
  assign w_fire    = w_valid_i && w_ready_o;
  assign w_keep    = w_fire && (NUM_COL_WIDTH'(w_col_i) < pe_filter_size_o);
  assign feat_fire = feat_valid_i && feat_ready_o;

  pe_feed_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_feat_counter (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       ((state == ST_IDLE) && cfg_valid_i),
    .load_value (cfg_num_feat_i),
    .dec        (feat_fire),
    .count      (feat_count),
    .zero       (feat_zero)
  );

  pe_feed_counter #(
    .WIDTH (NUM_COL_WIDTH)
  ) u_drain_counter (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (state == ST_ARM),
    .load_value (pe_filter_size_o),
    .dec        (state == ST_DRAIN),
    .count      (drain_count),
    .zero       (drain_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      entry_cnt        <= '0;
      w_ready_o        <= 1'b0;
      feat_ready_o     <= 1'b0;
      pe_load_o        <= 1'b0;
      pe_ready_o       <= 1'b0;
      pe_start_op_o    <= 1'b0;
      pe_f_weight_o    <= '0;
      pe_f_sel_o       <= '0;
      pe_column_num_o  <= '0;
      pe_row_num_o     <= '0;
      pe_filter_size_o <= '0;
      pe_in_feature_o  <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      pe_load_o  <= 1'b0;
      pe_ready_o <= 1'b0;
      done_o     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            pe_filter_size_o <= cfg_filter_size_i;
            pe_row_num_o     <= cfg_row_num_i;
            entry_cnt        <= '0;
            err_o            <= 1'b0;
            w_ready_o        <= 1'b1;
            busy_o           <= 1'b1;
            state            <= ST_LOAD_W;
          end
        end

        ST_LOAD_W: begin
          if (w_fire) begin
            if (w_keep) begin
              pe_load_o     <= 1'b1;
              pe_f_weight_o <= w_data_i;
              pe_f_sel_o    <= w_col_i;
              entry_cnt     <= entry_cnt + 1'b1;
            end else begin
              err_o <= 1'b1;
            end
            // The N-th kept entry closes the load even without w_last.
            if (w_last_i || (w_keep && (entry_cnt == N_MAX - 1'b1))) begin
              w_ready_o <= 1'b0;
              state     <= ST_ARM;
            end
          end
        end

        ST_ARM: begin
          pe_column_num_o <= entry_cnt;
          pe_ready_o      <= 1'b1;
          pe_start_op_o   <= 1'b1;
          if (feat_zero) begin
            state <= ST_DRAIN;
          end else begin
            feat_ready_o <= 1'b1;
            state        <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (feat_fire) begin
            pe_in_feature_o <= feat_data_i;
            if (feat_count == CNT_WIDTH'(1)) begin
              feat_ready_o <= 1'b0;
              state        <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Drain counter starts at filter_size; leaving on 1 gives filter_size cycles.
          if (drain_zero || (drain_count == NUM_COL_WIDTH'(1))) begin
            pe_start_op_o <= 1'b0;
            done_o        <= 1'b1;
            state         <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
